aes_inv_round_ctrl: RTL and testbench
=====================================

# aes_inv_round_ctrl

Iterative AES-128 decryption controller. It time-shares one combinational inverse-round datapath across all rounds: InverseShiftRows, InverseSubBytes, AddRoundKey, and the existing InverseMixColumns. It sequences one round per clock, fetches round keys from an external key table by index, and exchanges blocks with its neighbours over valid/ready handshakes. It sits between the ciphertext input buffer and the plaintext output stage of the decrypt path.

## Interface
- NR, 10, number of AES rounds (AES-128); the round counter and key index are sized from it.
- KEY_IDX_W, 4, width of keyIdx; must satisfy 2^KEY_IDX_W > NR.
- Clocking: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- inValid  input  1  a ciphertext block is present on dataIn.
- inReady  output  1  controller can accept a block; high only in IDLE.
- dataIn  input  128  ciphertext; uses the same column packing as the existing round modules.
- keyIdx  output  KEY_IDX_W  round-key index requested this cycle.
- roundKey  input  128  key for keyIdx, valid combinationally in the same cycle.
- abort  input  1  synchronous cancel of an in-flight block.
- outValid  output  1  plaintext on dataOut is valid.
- outReady  input  1  downstream accepts dataOut.
- dataOut  output  128  plaintext result, driven from a register.
- busy  output  1  high in ROUND or FINAL.
- round  output  KEY_IDX_W  current round counter, for debug.

## Operation
- FSM states: IDLE, ROUND, FINAL, OUT.
- IDLE
  - inReady=1, keyIdx=NR.
  - On inValid: stateReg <= dataIn ^ roundKey (initial AddRoundKey); round <= NR-1; go to ROUND.
- ROUND
  - keyIdx=round.
  - stateReg <= InvMixColumns(InvSubBytes(InvShiftRows(stateReg)) ^ roundKey).
  - If round==1: go to FINAL with round <= 0. Otherwise round <= round-1.
- FINAL
  - keyIdx=0.
  - dataOut <= InvSubBytes(InvShiftRows(stateReg)) ^ roundKey, with no InvMixColumns.
  - outValid <= 1; go to OUT.
- OUT
  - outValid=1; dataOut held stable.
  - On outReady: outValid <= 0; go to IDLE.
  - No new block is accepted in the same cycle as the output handshake.
- abort
  - In ROUND or FINAL: go to IDLE next cycle, outValid stays 0, the partial state is discarded.
  - In IDLE or OUT: ignored, so a completed result is never dropped.
- reset has priority over abort, and abort has priority over normal transitions.
- The datapath is purely combinational. It is muxed only by lastRound, which bypasses InvMixColumns.
- All state updates happen on the rising edge of clk.

## Timing
- Reset values:
  - state=IDLE, inReady=1, outValid=0, busy=0.
  - dataOut=0, stateReg=0, round=0, keyIdx=NR.
- Accept at cycle T gives:
  - ROUND in cycles T+1..T+NR-1 (9 cycles).
  - FINAL in cycle T+NR.
  - outValid high from cycle T+NR+1.
- Latency from accept to outValid is NR+1 = 11 cycles.
- Minimum block interval is NR+2 = 12 cycles with outReady held high.
- keyIdx is a function of state and round only. It does not depend on inValid, so the key table can be a ROM or register file with no extra latency.
- Downstream stall: outValid and dataOut hold indefinitely while outReady=0; inReady stays 0.
- reset asserted in any state returns all outputs to their reset values on the next edge.

## Structure
- Package aes_dec_pkg holds:
  - the FSM state enum (IDLE, ROUND, FINAL, OUT);
  - NR_AES128 = 10 and the KEY_IDX_W default;
  - a block type for 128-bit state.
- Sub-module aes_inv_round: combinational one-round datapath.
  - Inputs: stateIn, roundKey, lastRound. Output: stateOut.
  - Instantiates the existing InverseShiftRows, InverseSubBytes and InverseMixColumns modules.
- The controller module contains only the FSM, the round counter, stateReg, dataOut and the handshake logic.

## Test plan
- FIPS-197 C.1 vector: key 000102030405060708090a0b0c0d0e0f (bench-supplied key table, rk10=13111d7fe3944a17f307a78b4d2b30c5), dataIn 69c4e0d86a7b0430d8cdb78070b4c55a -> dataOut 00112233445566778899aabbccddeeff, outValid exactly 11 cycles after accept, keyIdx sequence 10,9,...,1,0.
- Back-to-back blocks with outReady=1 and inValid held high -> second accept occurs 12 cycles after the first; both results are correct.
- outReady=0 for 20 cycles after outValid -> dataOut and outValid stable, inReady=0; single outReady pulse -> IDLE next cycle.
- abort asserted at round 5 -> IDLE next cycle, outValid never rises; a following C.1 block decrypts correctly.
- abort asserted while in OUT -> ignored, result still delivered.
- reset asserted mid-ROUND and while in OUT -> next cycle inReady=1, outValid=0, dataOut=0, keyIdx=10, busy=0.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 decrypt path.
package aes_dec_pkg;

   localparam int NR_AES128     = 10;
   localparam int KEY_IDX_W_DEF = 4;

   // 128-bit AES state. Byte i (column i/4, row i%4) sits at bits [127-8*i -: 8].
   typedef logic [127:0] aes_block_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROUND,
      ST_FINAL,
      ST_OUT
   } dec_state_e;

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Shift-and-add GF(2^8) multiply.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = gf_xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   // Inverse S-box: undo the affine transform, then invert in the field.
   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] t;
      t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
      return gf_inv(t);
   endfunction

endpackage

// File: rtl/aes_inv_prims.sv
// Inverse round primitives shared by the decrypt datapath: InvShiftRows,
// InvSubBytes and InvMixColumns, all purely combinational.

module InverseShiftRows
   import aes_dec_pkg::*;
(
   input  aes_block_t stateIn,
   output aes_block_t stateOut
);
   // Row r rotates right by r columns: out[r][c] = in[r][(c-r) mod 4].
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign stateOut[127-8*(4*c+r) -: 8] = stateIn[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
   end
endmodule

module InverseSubBytes
   import aes_dec_pkg::*;
(
   input  aes_block_t stateIn,
   output aes_block_t stateOut
);
   for (genvar i = 0; i < 16; i++) begin : g_byte
      assign stateOut[8*i +: 8] = inv_sbox(stateIn[8*i +: 8]);
   end
endmodule

module InverseMixColumns
   import aes_dec_pkg::*;
(
   input  aes_block_t stateIn,
   output aes_block_t stateOut
);
   // Each column is multiplied by the circulant matrix {0e,0b,0d,09}.
   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = stateIn[127-32*c -: 8];
      assign a1 = stateIn[119-32*c -: 8];
      assign a2 = stateIn[111-32*c -: 8];
      assign a3 = stateIn[103-32*c -: 8];
      assign stateOut[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      assign stateOut[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      assign stateOut[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      assign stateOut[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
   end
endmodule

// File: rtl/aes_inv_round.sv
// One combinational inverse round. lastRound drops InvMixColumns for the final round.
module aes_inv_round
   import aes_dec_pkg::*;
(
   input  aes_block_t stateIn,
   input  aes_block_t roundKey,
   input  logic       lastRound,
   output aes_block_t stateOut
);
   aes_block_t shifted, subbed, keyed, mixed;

   InverseShiftRows  u_isr (.stateIn(stateIn), .stateOut(shifted));
   InverseSubBytes   u_isb (.stateIn(shifted), .stateOut(subbed));

   // AddRoundKey precedes InvMixColumns in the straight inverse cipher.
   assign keyed = subbed ^ roundKey;

   InverseMixColumns u_imc (.stateIn(keyed), .stateOut(mixed));

   assign stateOut = lastRound ? keyed : mixed;
endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decrypt controller: one inverse round per clock over a shared
// datapath, round keys fetched by index, valid/ready on both sides.
module aes_inv_round_ctrl
   import aes_dec_pkg::*;
#(
   parameter int NR        = NR_AES128,
   parameter int KEY_IDX_W = KEY_IDX_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inValid,
   output logic                 inReady,
   input  logic [127:0]         dataIn,
   output logic [KEY_IDX_W-1:0] keyIdx,
   input  logic [127:0]         roundKey,
   input  logic                 abort,
   output logic                 outValid,
   input  logic                 outReady,
   output logic [127:0]         dataOut,
   output logic                 busy,
   output logic [KEY_IDX_W-1:0] round
);
   localparam logic [KEY_IDX_W-1:0] NR_IDX   = KEY_IDX_W'(NR);
   localparam logic [KEY_IDX_W-1:0] LAST_IDX = KEY_IDX_W'(NR - 1);
   localparam logic [KEY_IDX_W-1:0] ONE_IDX  = KEY_IDX_W'(1);

   dec_state_e state, stateNxt;
   aes_block_t stateReg, dpOut;
   logic       lastRound;

   aes_inv_round u_dp (
      .stateIn  (stateReg),
      .roundKey (roundKey),
      .lastRound(lastRound),
      .stateOut (dpOut)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= stateNxt;
   end

   // Next state and state-decoded outputs; keyIdx never looks at inValid so the key
   // table can be a plain ROM/regfile read.
   always_comb begin
      stateNxt  = state;
      inReady   = 1'b0;
      busy      = 1'b0;
      outValid  = 1'b0;
      lastRound = 1'b0;
      keyIdx    = NR_IDX;
      case (state)
         ST_IDLE: begin
            inReady = 1'b1;
            if (inValid) stateNxt = ST_ROUND;
         end
         ST_ROUND: begin
            busy   = 1'b1;
            keyIdx = round;
            if (abort)                 stateNxt = ST_IDLE;
            else if (round == ONE_IDX) stateNxt = ST_FINAL;
         end
         ST_FINAL: begin
            busy      = 1'b1;
            keyIdx    = '0;
            lastRound = 1'b1;
            stateNxt  = abort ? ST_IDLE : ST_OUT;
         end
         ST_OUT: begin
            // abort is deliberately ignored here so a finished result is never lost
            outValid = 1'b1;
            if (outReady) stateNxt = ST_IDLE;
         end
         default: stateNxt = ST_IDLE;
      endcase
   end

   // Working state, round counter and output register; an abort leaves them untouched
   // and the partial block is simply overwritten by the next accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg <= '0;
         round    <= '0;
         dataOut  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (inValid) begin
                  stateReg <= dataIn ^ roundKey;
                  round    <= LAST_IDX;
               end
            end
            ST_ROUND: begin
               if (!abort) begin
                  stateReg <= dpOut;
                  round    <= round - ONE_IDX;
               end
            end
            ST_FINAL: begin
               if (!abort) dataOut <= dpOut;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Self-checking bench: byte-array AES reference decrypt with its own key schedule,
// randomized blocks plus directed handshake, abort and reset scenarios.
module tb_aes_inv_round_ctrl;
   localparam int NR = 10;
   localparam int KW = 4;
   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;

   logic          clk = 1'b0;
   logic          reset, inValid, inReady, abort, outValid, outReady, busy;
   logic [127:0]  dataIn, roundKey, dataOut;
   logic [KW-1:0] keyIdx, round;

   logic [127:0]  keyTab [0:NR];
   logic [7:0]    sbox  [256];
   logic [7:0]    isbox [256];
   int            errs   = 0;
   int            checks = 0;

   aes_inv_round_ctrl #(.NR(NR), .KEY_IDX_W(KW)) dut (
      .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady), .dataIn(dataIn),
      .keyIdx(keyIdx), .roundKey(roundKey), .abort(abort), .outValid(outValid),
      .outReady(outReady), .dataOut(dataOut), .busy(busy), .round(round)
   );

   always #5 clk = ~clk;

   // key table is a zero-latency lookup
   always_comb roundKey = (int'(keyIdx) <= NR) ? keyTab[keyIdx] : '0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box from first principles: brute-force field inverse, then forward affine map.
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] iv, b;
         iv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gm(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
         b = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]} ^ {iv[3:0], iv[7:4]} ^ 8'h63;
         sbox[x]  = b;
         isbox[b] = 8'(x);
      end
   endtask

   task automatic expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
            rc = gm(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= NR; r++) keyTab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] ref_dec(input logic [127:0] ct);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] k, res;
      k = keyTab[NR];
      for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ k[127-8*i -: 8];
      for (int rd = NR - 1; rd >= 0; rd--) begin
         k = keyTab[rd];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               t[r+4*c] = isbox[s[r+4*((c+4-r)%4)]] ^ k[127-8*(r+4*c) -: 8];
         if (rd > 0) begin
            for (int c = 0; c < 4; c++) begin
               s[4*c]   = gm(t[4*c],8'h0e) ^ gm(t[4*c+1],8'h0b) ^ gm(t[4*c+2],8'h0d) ^ gm(t[4*c+3],8'h09);
               s[4*c+1] = gm(t[4*c],8'h09) ^ gm(t[4*c+1],8'h0e) ^ gm(t[4*c+2],8'h0b) ^ gm(t[4*c+3],8'h0d);
               s[4*c+2] = gm(t[4*c],8'h0d) ^ gm(t[4*c+1],8'h09) ^ gm(t[4*c+2],8'h0e) ^ gm(t[4*c+3],8'h0b);
               s[4*c+3] = gm(t[4*c],8'h0b) ^ gm(t[4*c+1],8'h0d) ^ gm(t[4*c+2],8'h09) ^ gm(t[4*c+3],8'h0e);
            end
         end else begin
            s = t;
         end
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic rst_chk(input string tag);
      chk({tag, "_inReady"},  inReady,  1);
      chk({tag, "_outValid"}, outValid, 0);
      chk({tag, "_busy"},     busy,     0);
      chk({tag, "_dataOut"},  dataOut,  0);
      chk({tag, "_keyIdx"},   keyIdx,   NR);
      chk({tag, "_round"},    round,    0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!inReady && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle", inReady, 1);
   endtask

   task automatic start(input logic [127:0] ct);
      wait_idle();
      dataIn  = ct;
      inValid = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      dataIn  = rand128();
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!outValid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("wait_valid", outValid, 1);
   endtask

   // Full block: key index sequence, latency, result, optional stall, then release.
   task automatic run_block(input logic [127:0] ct, input logic [127:0] exp, input int stall);
      int           lat;
      logic         bad;
      logic [127:0] held;
      outReady = 1'b0;
      wait_idle();
      chk("idle_keyIdx", keyIdx, NR);
      dataIn  = ct;
      inValid = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      dataIn  = rand128();
      lat = 1;
      while (!outValid && lat < 40) begin
         chk("key_seq", keyIdx, NR - lat);
         chk("busy_run", busy, 1);
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, NR + 1);
      chk("result", dataOut, exp);
      chk("out_inReady", inReady, 0);
      chk("out_busy", busy, 0);
      held = dataOut;
      bad  = 1'b0;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         if (!outValid || dataOut !== held || inReady) bad = 1'b1;
      end
      if (stall > 0) chk("stall_hold", bad, 0);
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
      chk("release_outValid", outValid, 0);
      chk("release_inReady", inReady, 1);
   endtask

   initial begin
      logic [127:0] ct, ctB, expB;
      logic [127:0] res [2];
      int           accAt [2];
      int           nacc, got, lat, n;
      logic         bad;

      reset = 1'b1; inValid = 1'b0; abort = 1'b0; outReady = 1'b0; dataIn = '0;
      build_sbox();
      expand(KEY_C1);
      chk("model_rk10", keyTab[NR], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      chk("model_c1", ref_dec(CT_C1), PT_C1);
      repeat (3) @(negedge clk);
      rst_chk("reset");
      reset = 1'b0;

      // FIPS-197 C.1 vector, then the same block with a 20-cycle downstream stall
      run_block(CT_C1, PT_C1, 0);
      run_block(CT_C1, PT_C1, 20);

      // random keys and ciphertexts against the reference model
      for (int i = 0; i < 4; i++) begin
         expand(rand128());
         ct = rand128();
         run_block(ct, ref_dec(ct), $urandom_range(0, 3));
      end

      // back-to-back with inValid held high and outReady high
      expand(KEY_C1);
      ctB  = rand128();
      expB = ref_dec(ctB);
      wait_idle();
      outReady = 1'b1; inValid = 1'b1; dataIn = CT_C1;
      nacc = 0; got = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (outValid && got < 2) begin res[got] = dataOut; got++; end
         if (inReady && inValid && nacc < 2) begin accAt[nacc] = cyc; nacc++; end
         @(negedge clk);
         if (nacc == 1) dataIn = ctB;
         if (nacc == 2) inValid = 1'b0;
      end
      inValid = 1'b0; outReady = 1'b0;
      chk("b2b_accepts", nacc, 2);
      chk("b2b_results", got, 2);
      if (nacc == 2) chk("b2b_interval", accAt[1] - accAt[0], NR + 2);
      if (got == 2) begin
         chk("b2b_first", res[0], PT_C1);
         chk("b2b_second", res[1], expB);
      end

      // abort at round 5
      start(CT_C1);
      n = 0;
      while (round != KW'(5) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reach_r5", round, 5);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_inReady", inReady, 1);
      chk("abort_busy", busy, 0);
      bad = 1'b0;
      repeat (15) begin
         if (outValid) bad = 1'b1;
         @(negedge clk);
      end
      chk("abort_no_out", bad, 0);
      run_block(CT_C1, PT_C1, 0);

      // abort while holding a result is ignored
      start(CT_C1);
      wait_valid(lat);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_out_valid", outValid, 1);
      chk("abort_out_data", dataOut, PT_C1);
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
      chk("abort_out_done", inReady, 1);

      // reset mid-ROUND and while holding a result
      start(CT_C1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      rst_chk("rst_round");
      reset = 1'b0;
      start(CT_C1);
      wait_valid(lat);
      reset = 1'b1;
      @(negedge clk);
      rst_chk("rst_out");
      reset = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
